fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter IW, default 10, program counter width and instruction ROM address width.
REQ-002 Parameter DW, default 9, machine code width.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  single-cycle pulse; begins or restarts execution at address 0.
REQ-006 Stall  input  1  holds fetch state while high.
REQ-007 BranchEn  input  1  redirect request for the instruction currently on Inst.
REQ-008 BranchAbs  input  1  1 = BranchTarget is an absolute address; 0 = two's-complement offset.
REQ-009 BranchTarget  input  IW  absolute target or signed offset.
REQ-010 HaltReq  input  1  stop request for the instruction currently on Inst.
REQ-011 InstIn  input  DW  combinational instruction-ROM read data for InstAddress.
REQ-012 InstAddress  output  IW  registered PC; drives instruction-ROM address.
REQ-013 Inst  output  DW  registered instruction to the decoder.
REQ-014 InstPC  output  IW  address Inst was fetched from.
REQ-015 InstValid  output  1  Inst/InstPC hold a live instruction.
REQ-016 Busy  output  1  high in RUN.
REQ-017 Done  output  1  high in DONE.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE; Busy = (state==RUN), Done = (state==DONE), both registered.
REQ-019 IDLE/DONE, Start=1: next state RUN, PC <= 0, InstValid <= 0; otherwise state, PC and all outputs hold.
REQ-020 RUN, no Stall/BranchEn/HaltReq: Inst <= InstIn, InstPC <= PC, InstValid <= 1, PC <= PC+1.
REQ-021 Fetch latency SHALL be one cycle: the address on InstAddress in cycle n appears on Inst/InstPC with InstValid=1 in cycle n+1.
REQ-022 PC increment SHALL wrap modulo 2^IW (2^IW-1 -> 0) with no flag.
REQ-023 RUN, BranchEn=1 and InstValid=1: PC <= BranchTarget if BranchAbs, else InstPC + BranchTarget (modulo 2^IW); InstValid <= 0 (wrong-path fetch squashed). Penalty is exactly one bubble.
REQ-024 BranchEn or HaltReq while InstValid=0 SHALL be ignored.
REQ-025 RUN, Stall=1, no BranchEn: PC, Inst, InstPC, InstValid hold.
REQ-026 BranchEn SHALL take priority over Stall; HaltReq SHALL take priority over BranchEn and Stall.
REQ-027 RUN, HaltReq=1 and InstValid=1: next state DONE, InstValid <= 0, PC holds.
REQ-028 Start while in RUN SHALL be ignored.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 Reset=1 at a rising edge SHALL force state IDLE, PC=0, Inst=0, InstPC=0, InstValid=0, Busy=0, Done=0, overriding every other input in any state, including mid-RUN.
REQ-031 First Start is accepted on the first edge after Reset deasserts.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum (IDLE, RUN, DONE) and default constants IW=10, DW=9.
REQ-033 One sub-module pc_next (combinational next-PC mux: increment, absolute, relative, hold) SHALL be used; FSM and registers stay in fetch_unit.

Verification
REQ-034 Reset, Start pulse, ROM model with rom[k]=k: InstAddress 0,1,2,3 on consecutive cycles; Inst=0 with InstPC=0 and InstValid=1 one cycle after InstAddress=0.
REQ-035 Absolute branch, BranchEn=1, BranchAbs=1, BranchTarget=20 while InstPC=5: next cycle InstValid=0, InstAddress=20; following cycle InstPC=20, InstValid=1.
REQ-036 Relative branch while InstPC=10, BranchTarget=10'h3FC (-4): InstAddress=6, then InstPC=6 after one bubble; offset +5 at InstPC=1022 yields target 3.
REQ-037 Stall high 3 cycles with InstAddress=7: InstAddress, Inst, InstPC, InstValid unchanged for 3 cycles; after release InstPC=7 then 8. Stall+BranchEn together: branch taken.
REQ-038 Wrap: run from PC 1022: InstAddress 1022, 1023, 0, 1; InstPC follows one cycle later.
REQ-039 HaltReq at InstPC=12: next cycle Done=1, Busy=0, InstValid=0, InstAddress frozen; Start -> RUN from 0; Reset asserted mid-RUN at PC=9 -> next cycle IDLE, InstAddress=0, all outputs 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned IW_DEFAULT = 10;
    localparam int unsigned DW_DEFAULT = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_ABS  = 2'd2,
        PC_REL  = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC mux: hold, sequential increment, absolute target, or offset from
// the PC of the instruction that requested the branch.
module pc_next
    import fetch_pkg::*;
#(
    parameter int unsigned IW = IW_DEFAULT
) (
    input  logic [IW-1:0] pc_i,
    input  logic [IW-1:0] inst_pc_i,
    input  logic [IW-1:0] target_i,
    input  pc_sel_e       sel_i,
    output logic [IW-1:0] npc_c_o
);

    // Select next PC; all arithmetic wraps modulo 2^IW
    always_comb begin
        npc_c_o = pc_i;
        case (sel_i)
            PC_INC:  npc_c_o = pc_i + IW'(1);
            PC_ABS:  npc_c_o = target_i;
            PC_REL:  npc_c_o = inst_pc_i + target_i;
            default: npc_c_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch: PC register, one-cycle ROM fetch, branch
// redirect with a one-bubble squash, stall and halt control.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned IW = IW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchAbs,
    input  logic [IW-1:0] BranchTarget,
    input  logic          HaltReq,
    input  logic [DW-1:0] InstIn,
    output logic [IW-1:0] InstAddress,
    output logic [DW-1:0] Inst,
    output logic [IW-1:0] InstPC,
    output logic          InstValid,
    output logic          Busy,
    output logic          Done
);

    state_e        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [DW-1:0] inst_q, inst_d;
    logic [IW-1:0] inst_pc_q, inst_pc_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    pc_sel_e       pc_sel;
    logic [IW-1:0] npc;

    // Next-PC source; halt outranks branch, branch outranks stall
    always_comb begin
        pc_sel = PC_HOLD;
        if (state_q == RUN) begin
            if (HaltReq && valid_q) begin
                pc_sel = PC_HOLD;
            end else if (BranchEn && valid_q) begin
                pc_sel = BranchAbs ? PC_ABS : PC_REL;
            end else if (!Stall) begin
                pc_sel = PC_INC;
            end
        end
    end

    pc_next #(.IW(IW)) u_pc_next (
        .pc_i      (pc_q),
        .inst_pc_i (inst_pc_q),
        .target_i  (BranchTarget),
        .sel_i     (pc_sel),
        .npc_c_o   (npc)
    );

    // Next-state and next-register values
    always_comb begin
        state_d   = state_q;
        pc_d      = npc;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                if (HaltReq && valid_q) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                end else if (BranchEn && valid_q) begin
                    // Squash the wrong-path word fetched this cycle
                    valid_d = 1'b0;
                end else if (!Stall) begin
                    inst_d    = InstIn;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign InstAddress = pc_q;
    assign Inst        = inst_q;
    assign InstPC      = inst_pc_q;
    assign InstValid   = valid_q;
    assign Busy        = busy_q;
    assign Done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a rom[k]=k instruction model; the driver
// queues expected outputs per cycle and a negedge monitor checks them.
module tb_fetch_unit;

    localparam int unsigned IW = 10;
    localparam int unsigned DW = 9;

    logic          Clk;
    logic          Reset;
    logic          Start;
    logic          Stall;
    logic          BranchEn;
    logic          BranchAbs;
    logic [IW-1:0] BranchTarget;
    logic          HaltReq;
    logic [DW-1:0] InstIn;
    logic [IW-1:0] InstAddress;
    logic [DW-1:0] Inst;
    logic [IW-1:0] InstPC;
    logic          InstValid;
    logic          Busy;
    logic          Done;

    typedef struct {
        int            tag;
        string         name;
        logic [IW-1:0] addr;
        logic [IW-1:0] ipc;
        logic          v;
        logic          b;
        logic          d;
        bit            cipc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    fetch_unit #(.IW(IW), .DW(DW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Stall        (Stall),
        .BranchEn     (BranchEn),
        .BranchAbs    (BranchAbs),
        .BranchTarget (BranchTarget),
        .HaltReq      (HaltReq),
        .InstIn       (InstIn),
        .InstAddress  (InstAddress),
        .Inst         (Inst),
        .InstPC       (InstPC),
        .InstValid    (InstValid),
        .Busy         (Busy),
        .Done         (Done)
    );

    // Instruction ROM: rom[k] = k truncated to the machine-code width
    assign InstIn = InstAddress[DW-1:0];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has arrived
    always @(negedge Clk) begin
        exp_t e;
        bit   ok;
        logic [DW-1:0] exp_inst;
        while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
            e = exp_q.pop_front();
            exp_inst = e.ipc[DW-1:0];
            ok = (e.tag == cyc) && (InstAddress === e.addr) && (InstValid === e.v)
                 && (Busy === e.b) && (Done === e.d);
            if (e.cipc)
                ok = ok && (InstPC === e.ipc) && (Inst === exp_inst);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s cyc=%0d got addr=%0d ipc=%0d inst=%0d v=%b busy=%b done=%b want addr=%0d ipc=%0d(chk=%0b) v=%b busy=%b done=%b",
                         e.name, cyc, InstAddress, InstPC, Inst, InstValid, Busy, Done,
                         e.addr, e.ipc, e.cipc, e.v, e.b, e.d);
            end
        end
    end

    // Queue the expected outputs after the next edge, then advance one cycle
    task automatic expect_next(input string nm, input int addr, input int ipc,
                               input logic v, input logic b, input logic d, input bit cipc);
        exp_t e;
        e.tag  = cyc + 1;
        e.name = nm;
        e.addr = IW'(addr);
        e.ipc  = IW'(ipc);
        e.v    = v;
        e.b    = b;
        e.d    = d;
        e.cipc = cipc;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start        = 1'b0;
        Stall        = 1'b0;
        BranchEn     = 1'b0;
        BranchAbs    = 1'b0;
        BranchTarget = '0;
        HaltReq      = 1'b0;
    endtask

    task automatic branch(input logic abs, input int tgt);
        BranchEn     = 1'b1;
        BranchAbs    = abs;
        BranchTarget = IW'(tgt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d timed out", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        idle_inputs();
        @(posedge Clk);
        #1;
        expect_next("reset", 0, 0, 0, 0, 0, 1);

        // Start on the first edge after reset release, sequential fetch
        Reset = 1'b0;
        Start = 1'b1;
        expect_next("start", 0, 0, 0, 1, 0, 0);
        Start = 1'b0;
        for (int k = 0; k < 6; k++)
            expect_next("fetch_seq", k + 1, k, 1, 1, 0, 1);

        // Absolute branch at InstPC=5
        branch(1'b1, 20);
        expect_next("babs_bubble", 20, 5, 0, 1, 0, 0);
        idle_inputs();
        expect_next("babs_target", 21, 20, 1, 1, 0, 1);

        // Relative -4 at InstPC=10; redirect/halt during the bubble are ignored
        branch(1'b1, 10);
        expect_next("babs_to10", 10, 20, 0, 1, 0, 0);
        idle_inputs();
        expect_next("fetch10", 11, 10, 1, 1, 0, 1);
        branch(1'b0, 10'h3FC);
        expect_next("brel_bubble", 6, 10, 0, 1, 0, 0);
        branch(1'b1, 100);
        HaltReq = 1'b1;
        expect_next("invalid_ignored", 7, 6, 1, 1, 0, 1);
        idle_inputs();

        // Stall three cycles with InstAddress=7
        Stall = 1'b1;
        for (int k = 0; k < 3; k++)
            expect_next("stall_hold", 7, 6, 1, 1, 0, 1);
        Stall = 1'b0;
        expect_next("stall_release", 8, 7, 1, 1, 0, 1);
        expect_next("stall_release2", 9, 8, 1, 1, 0, 1);

        // Branch wins over stall
        Stall = 1'b1;
        branch(1'b1, 30);
        expect_next("stall_branch", 30, 8, 0, 1, 0, 0);
        idle_inputs();
        expect_next("stall_branch_tgt", 31, 30, 1, 1, 0, 1);

        // Relative +5 from 1022 wraps to 3
        branch(1'b1, 1022);
        expect_next("babs_1022", 1022, 30, 0, 1, 0, 0);
        idle_inputs();
        expect_next("fetch1022", 1023, 1022, 1, 1, 0, 1);
        branch(1'b0, 5);
        expect_next("brel_wrap", 3, 1022, 0, 1, 0, 0);
        idle_inputs();
        expect_next("brel_wrap_tgt", 4, 3, 1, 1, 0, 1);

        // Sequential PC wrap 1022,1023,0,1
        branch(1'b1, 1022);
        expect_next("babs_1022b", 1022, 3, 0, 1, 0, 0);
        idle_inputs();
        expect_next("wrap_a", 1023, 1022, 1, 1, 0, 1);
        expect_next("wrap_b", 0, 1023, 1, 1, 0, 1);
        expect_next("wrap_c", 1, 0, 1, 1, 0, 1);
        expect_next("wrap_d", 2, 1, 1, 1, 0, 1);

        // Halt at InstPC=12 outranks branch and stall
        branch(1'b1, 12);
        expect_next("babs_12", 12, 1, 0, 1, 0, 0);
        idle_inputs();
        expect_next("fetch12", 13, 12, 1, 1, 0, 1);
        HaltReq = 1'b1;
        Stall   = 1'b1;
        branch(1'b1, 50);
        expect_next("halt", 13, 12, 0, 0, 1, 0);
        idle_inputs();
        branch(1'b1, 60);
        expect_next("done_hold", 13, 12, 0, 0, 1, 0);
        idle_inputs();

        // Restart from DONE; Start during RUN is ignored
        Start = 1'b1;
        expect_next("restart", 0, 0, 0, 1, 0, 0);
        Start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            Start = (k == 3);
            expect_next("refetch", k + 1, k, 1, 1, 0, 1);
        end
        Start = 1'b0;

        // Reset mid-RUN at PC=9 overrides everything
        Reset = 1'b1;
        Start = 1'b1;
        branch(1'b1, 40);
        expect_next("reset_mid_run", 0, 0, 0, 0, 0, 1);
        Reset = 1'b0;
        idle_inputs();
        expect_next("idle_after_reset", 0, 0, 0, 0, 0, 1);
        Start = 1'b1;
        expect_next("start_again", 0, 0, 0, 1, 0, 0);
        Start = 1'b0;
        expect_next("fetch_again", 1, 0, 1, 1, 0, 1);

        @(negedge Clk);
        @(negedge Clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
